pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Pipeline scheduler for the 5-stage core, sitting beside the ID stage. It tracks in-flight register writes in a per-GPR scoreboard and detects read-after-write hazards on the instruction in ID. It generates the stall, flush, bubble and freeze controls for the PC, IF_ID, ID_EXE and later pipeline registers. Arbitration between data-memory wait, EXE branch redirect and RAW hazards is resolved here, one decision per cycle.

## Interface
Parameters:
- NUM_GPR, 32, number of general-purpose registers; x0 is never tracked.
- GPR_ADDR_W, 5, register address width.
- CNT_W, 2, pending-write counter width per register. Covers the maximum of 3 in flight (EXE, MEM, WB).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_valid_i  in  1  ID holds a valid instruction.
- rs1_addr_i / rs2_addr_i  in  GPR_ADDR_W  ID source register addresses.
- rs1_used_i / rs2_used_i  in  1  source operand is actually read by the instruction.
- rd_addr_i  in  GPR_ADDR_W  ID destination address.
- rd_we_i  in  1  ID instruction writes rd.
- wb_valid_i  in  1  WB stage holds a valid instruction.
- wb_rd_addr_i  in  GPR_ADDR_W  WB destination address.
- wb_rd_we_i  in  1  WB writes the regfile this cycle.
- exe_redirect_i  in  1  taken branch/jump resolved in EXE.
- mem_busy_i  in  1  data memory not ready; MEM cannot advance.
- pc_stall_o  out  1  hold PC.
- if_id_stall_o  out  1  hold IF_ID.
- if_id_flush_o  out  1  clear IF_ID to NOP.
- id_exe_bubble_o  out  1  load a NOP into ID_EXE.
- pipe_freeze_o  out  1  hold ID_EXE, EXE_MEM, MEM_WB.
- issue_o  out  1  ID instruction advances to EXE this cycle.
- state_o  out  2  registered last-cycle decision: RUN=0, HAZ=1, MEM=2, FLUSH=3.
- sb_err_o  out  1  sticky scoreboard underflow/overflow flag.

## Operation
- Hazard: id_valid_i and, for either source, used and addr≠0 and cnt[addr]≠0. Exception: a source is not hazardous if cnt[addr]==1 and WB writes that address this cycle (regfile write-through).
- Priority per cycle is mem_busy_i > exe_redirect_i > hazard > run.
  - MEM: pipe_freeze, pc_stall, if_id_stall=1; issue=0; no scoreboard change, including WB, which is frozen.
  - FLUSH: if_id_flush=1, id_exe_bubble=1, pc_stall=0 (PC loads target); issue=0.
  - HAZ: pc_stall, if_id_stall, id_exe_bubble=1; issue=0.
  - RUN: all controls 0; issue_o=id_valid_i.
- Scoreboard, when not MEM:
  - +1 on cnt[rd_addr_i] if issue_o & rd_we_i & rd≠0.
  - −1 on cnt[wb_rd_addr_i] if wb_valid_i & wb_rd_we_i & wb_rd≠0.
  - Same register incremented and decremented in one cycle: unchanged.
- Decrement at 0 or increment at 2^CNT_W−1: the update is dropped and sb_err_o is set until reset.
- state_o: next = decision of the current cycle.
- Reset: all counters 0, state_o=RUN, sb_err_o=0. Control outputs follow their combinational definition; with inputs idle, all are 0.

## Timing
- All control outputs and issue_o are combinational from inputs and registered counters, valid in the same cycle. There is no added latency.
- Scoreboard and state_o update at the edge ending the cycle.
- Dependent instruction behind a non-load ALU op, no forwarding: the producer passes through EXE, MEM and WB. The consumer issues in the producer's WB cycle (write-through), giving 2 HAZ cycles.
- Redirect during a hazard: FLUSH wins and the wrong-path instruction is discarded without issuing.
- mem_busy_i held N cycles gives N consecutive MEM cycles. On release, the same decision logic re-evaluates with unchanged counters.
- rst_n asserted mid-stall: immediate return to reset values; in-flight counts are discarded.

## Configuration
- HAZ_CTRL_PERF_EN defined: adds hz_stall_cnt_o, mem_stall_cnt_o and flush_cnt_o, each out 32.
  - Each increments once per HAZ, MEM or FLUSH cycle respectively and wraps at 2^32.
  - Each resets to 0.
- Undefined: these ports and their registers are absent. Behaviour is otherwise identical.

## Structure
- Shared package: state encoding (RUN/HAZ/MEM/FLUSH), NUM_GPR, GPR_ADDR_W, CNT_W.
- Sub-module hazard_scoreboard: the counter array with inc/dec ports, two read ports and an error output.
- The top level holds the priority logic, the state register and the optional perf counters.

## Test plan
- Reset, then issue addi x5 with no WB: cnt[5]=1, issue_o=1, state_o=RUN next cycle.
- x5 pending (cnt=1), ID reads rs1=x5: pc_stall=if_id_stall=id_exe_bubble=1 and issue=0. Assert WB x5 in the same cycle: issue=1 and cnt[5] stays 1 (inc+dec).
- Hazard and exe_redirect_i in the same cycle: if_id_flush=1, id_exe_bubble=1, pc_stall=0, state_o=FLUSH, no counter change.
- mem_busy_i for 3 cycles with WB x7 pending: pipe_freeze=1 for all 3, cnt[7] unchanged; after release, cnt[7] decrements.
- Reads or writes of x0, and WB x3 with cnt[3]=0: no hazard and no count for x0; sb_err_o=1 and cnt[3] stays 0.
- With HAZ_CTRL_PERF_EN: a 2-cycle hazard, 3-cycle mem wait and 1 redirect give hz=2, mem=3, flush=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the ID-stage pipeline scheduler.
// Holds the decision/state encoding and the default register-file geometry.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned NUM_GPR    = 32;
  localparam int unsigned GPR_ADDR_W = 5;
  localparam int unsigned CNT_W      = 2;
  localparam int unsigned PERF_W     = 32;

  // One scheduling decision per cycle; also the encoding of state_o.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_HAZ   = 2'd1,
    ST_MEM   = 2'd2,
    ST_FLUSH = 2'd3
  } state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-GPR pending-write counters.
// Ports: inc_en_i/inc_addr_i add an in-flight write, dec_en_i/dec_addr_i retire
// one; rd0/rd1 are combinational count reads; err_o is a sticky flag raised on
// a dropped increment at saturation or decrement at zero. Callers never target x0.
module hazard_scoreboard #(
  parameter int unsigned NUM_GPR    = pipe_hazard_ctrl_pkg::NUM_GPR,
  parameter int unsigned GPR_ADDR_W = pipe_hazard_ctrl_pkg::GPR_ADDR_W,
  parameter int unsigned CNT_W      = pipe_hazard_ctrl_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc_en_i,
  input  logic [GPR_ADDR_W-1:0] inc_addr_i,
  input  logic                  dec_en_i,
  input  logic [GPR_ADDR_W-1:0] dec_addr_i,
  input  logic [GPR_ADDR_W-1:0] rd0_addr_i,
  input  logic [GPR_ADDR_W-1:0] rd1_addr_i,
  output logic [CNT_W-1:0]      rd0_cnt_o,
  output logic [CNT_W-1:0]      rd1_cnt_o,
  output logic                  err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NUM_GPR];
  logic [CNT_W-1:0] cnt_d [NUM_GPR];
  logic             err_q;
  logic             err_d;

  // Counter update; an inc and dec on the same register cancel out.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    for (int unsigned i = 1; i < NUM_GPR; i++) begin
      if (inc_en_i && (inc_addr_i == GPR_ADDR_W'(i)) &&
          !(dec_en_i && (dec_addr_i == GPR_ADDR_W'(i)))) begin
        if (cnt_q[i] == CNT_MAX) err_d = 1'b1;
        else                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (dec_en_i && (dec_addr_i == GPR_ADDR_W'(i)) &&
                   !(inc_en_i && (inc_addr_i == GPR_ADDR_W'(i)))) begin
        if (cnt_q[i] == '0) err_d = 1'b1;
        else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_GPR; i++) cnt_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign rd0_cnt_o = cnt_q[rd0_addr_i];
  assign rd1_cnt_o = cnt_q[rd1_addr_i];
  assign err_o     = err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ID-stage pipeline scheduler: RAW hazard detection against a pending-write
// scoreboard and arbitration of mem wait > EXE redirect > hazard > run.
// Inputs: ID operand/destination info, WB write info, exe_redirect_i, mem_busy_i.
// Outputs: same-cycle pc/IF_ID/ID_EXE/freeze controls and issue_o, registered
// state_o (last decision) and sticky sb_err_o.
// Optional HAZ_CTRL_PERF_EN adds hz_stall_cnt_o, mem_stall_cnt_o, flush_cnt_o.
module pipe_hazard_ctrl #(
  parameter int unsigned NUM_GPR    = pipe_hazard_ctrl_pkg::NUM_GPR,
  parameter int unsigned GPR_ADDR_W = pipe_hazard_ctrl_pkg::GPR_ADDR_W,
  parameter int unsigned CNT_W      = pipe_hazard_ctrl_pkg::CNT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid_i,
  input  logic [GPR_ADDR_W-1:0] rs1_addr_i,
  input  logic [GPR_ADDR_W-1:0] rs2_addr_i,
  input  logic                  rs1_used_i,
  input  logic                  rs2_used_i,
  input  logic [GPR_ADDR_W-1:0] rd_addr_i,
  input  logic                  rd_we_i,
  input  logic                  wb_valid_i,
  input  logic [GPR_ADDR_W-1:0] wb_rd_addr_i,
  input  logic                  wb_rd_we_i,
  input  logic                  exe_redirect_i,
  input  logic                  mem_busy_i,
  output logic                  pc_stall_o,
  output logic                  if_id_stall_o,
  output logic                  if_id_flush_o,
  output logic                  id_exe_bubble_o,
  output logic                  pipe_freeze_o,
  output logic                  issue_o,
  output logic [1:0]            state_o,
`ifdef HAZ_CTRL_PERF_EN
  output logic [31:0]           hz_stall_cnt_o,
  output logic [31:0]           mem_stall_cnt_o,
  output logic [31:0]           flush_cnt_o,
`endif
  output logic                  sb_err_o
);

  import pipe_hazard_ctrl_pkg::*;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rs1_cnt, rs2_cnt;
  logic             wb_dec_c, rs1_haz_c, rs2_haz_c, hazard_c;
  logic             pc_stall_c, if_id_stall_c, if_id_flush_c;
  logic             bubble_c, freeze_c, issue_c;

  assign wb_dec_c = wb_valid_i && wb_rd_we_i && (wb_rd_addr_i != '0);

  // A single pending write retiring in WB this cycle is visible via write-through.
  assign rs1_haz_c = rs1_used_i && (rs1_addr_i != '0) && (rs1_cnt != '0) &&
                     !((rs1_cnt == CNT_W'(1)) && wb_dec_c && (wb_rd_addr_i == rs1_addr_i));
  assign rs2_haz_c = rs2_used_i && (rs2_addr_i != '0) && (rs2_cnt != '0) &&
                     !((rs2_cnt == CNT_W'(1)) && wb_dec_c && (wb_rd_addr_i == rs2_addr_i));
  assign hazard_c  = id_valid_i && (rs1_haz_c || rs2_haz_c);

  // Per-cycle decision and the controls it implies.
  always_comb begin
    state_d       = ST_RUN;
    pc_stall_c    = 1'b0;
    if_id_stall_c = 1'b0;
    if_id_flush_c = 1'b0;
    bubble_c      = 1'b0;
    freeze_c      = 1'b0;
    issue_c       = 1'b0;
    if (mem_busy_i) begin
      state_d       = ST_MEM;
      freeze_c      = 1'b1;
      pc_stall_c    = 1'b1;
      if_id_stall_c = 1'b1;
    end else if (exe_redirect_i) begin
      state_d       = ST_FLUSH;
      if_id_flush_c = 1'b1;
      bubble_c      = 1'b1;
    end else if (hazard_c) begin
      state_d       = ST_HAZ;
      pc_stall_c    = 1'b1;
      if_id_stall_c = 1'b1;
      bubble_c      = 1'b1;
    end else begin
      issue_c       = id_valid_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  // WB is frozen along with the rest of the pipe during a memory wait.
  hazard_scoreboard #(
    .NUM_GPR    (NUM_GPR),
    .GPR_ADDR_W (GPR_ADDR_W),
    .CNT_W      (CNT_W)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .inc_en_i   (issue_c && rd_we_i && (rd_addr_i != '0)),
    .inc_addr_i (rd_addr_i),
    .dec_en_i   (!mem_busy_i && wb_dec_c),
    .dec_addr_i (wb_rd_addr_i),
    .rd0_addr_i (rs1_addr_i),
    .rd1_addr_i (rs2_addr_i),
    .rd0_cnt_o  (rs1_cnt),
    .rd1_cnt_o  (rs2_cnt),
    .err_o      (sb_err_o)
  );

  assign pc_stall_o      = pc_stall_c;
  assign if_id_stall_o   = if_id_stall_c;
  assign if_id_flush_o   = if_id_flush_c;
  assign id_exe_bubble_o = bubble_c;
  assign pipe_freeze_o   = freeze_c;
  assign issue_o         = issue_c;
  assign state_o         = state_q;

`ifdef HAZ_CTRL_PERF_EN
  logic [PERF_W-1:0] hz_cnt_q, mem_cnt_q, flush_cnt_q;

  // Free-running cycle counters per decision kind; wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hz_cnt_q    <= '0;
      mem_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (state_d == ST_HAZ)   hz_cnt_q    <= hz_cnt_q + PERF_W'(1);
      if (state_d == ST_MEM)   mem_cnt_q   <= mem_cnt_q + PERF_W'(1);
      if (state_d == ST_FLUSH) flush_cnt_q <= flush_cnt_q + PERF_W'(1);
    end
  end

  assign hz_stall_cnt_o  = hz_cnt_q;
  assign mem_stall_cnt_o = mem_cnt_q;
  assign flush_cnt_o     = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a queue of expected control vectors.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic       clk, rst_n;
  logic       id_valid_i, rs1_used_i, rs2_used_i, rd_we_i;
  logic [4:0] rs1_addr_i, rs2_addr_i, rd_addr_i, wb_rd_addr_i;
  logic       wb_valid_i, wb_rd_we_i, exe_redirect_i, mem_busy_i;
  logic       pc_stall_o, if_id_stall_o, if_id_flush_o, id_exe_bubble_o;
  logic       pipe_freeze_o, issue_o, sb_err_o;
  logic [1:0] state_o;
`ifdef HAZ_CTRL_PERF_EN
  logic [31:0] hz_stall_cnt_o, mem_stall_cnt_o, flush_cnt_o;
`endif

  pipe_hazard_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_valid_i      (id_valid_i),
    .rs1_addr_i      (rs1_addr_i),
    .rs2_addr_i      (rs2_addr_i),
    .rs1_used_i      (rs1_used_i),
    .rs2_used_i      (rs2_used_i),
    .rd_addr_i       (rd_addr_i),
    .rd_we_i         (rd_we_i),
    .wb_valid_i      (wb_valid_i),
    .wb_rd_addr_i    (wb_rd_addr_i),
    .wb_rd_we_i      (wb_rd_we_i),
    .exe_redirect_i  (exe_redirect_i),
    .mem_busy_i      (mem_busy_i),
    .pc_stall_o      (pc_stall_o),
    .if_id_stall_o   (if_id_stall_o),
    .if_id_flush_o   (if_id_flush_o),
    .id_exe_bubble_o (id_exe_bubble_o),
    .pipe_freeze_o   (pipe_freeze_o),
    .issue_o         (issue_o),
    .state_o         (state_o),
`ifdef HAZ_CTRL_PERF_EN
    .hz_stall_cnt_o  (hz_stall_cnt_o),
    .mem_stall_cnt_o (mem_stall_cnt_o),
    .flush_cnt_o     (flush_cnt_o),
`endif
    .sb_err_o        (sb_err_o)
  );

  // {pc_stall, if_id_stall, if_id_flush, bubble, freeze, issue}
  localparam logic [5:0] C_IDLE = 6'b000000;
  localparam logic [5:0] C_ISS  = 6'b000001;
  localparam logic [5:0] C_HAZ  = 6'b110100;
  localparam logic [5:0] C_MEM  = 6'b110010;
  localparam logic [5:0] C_FL   = 6'b001100;

  logic [5:0] ctrl;
  assign ctrl = {pc_stall_o, if_id_stall_o, if_id_flush_o, id_exe_bubble_o,
                 pipe_freeze_o, issue_o};

  int         vectors = 0;
  int         miscompares = 0;
  logic [5:0] exp_ctrl_q [$];
  logic [1:0] exp_state_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    id_valid_i = 0; rs1_addr_i = 0; rs1_used_i = 0; rs2_addr_i = 0; rs2_used_i = 0;
    rd_addr_i = 0; rd_we_i = 0; wb_valid_i = 0; wb_rd_addr_i = 0; wb_rd_we_i = 0;
    exe_redirect_i = 0; mem_busy_i = 0;
  endtask

  // One cycle: drive at negedge, check controls mid-cycle, state after the edge.
  task automatic step(input string tag, input logic iv,
                      input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2,
                      input logic [4:0] rd, input logic we,
                      input logic wv, input logic [4:0] wrd,
                      input logic redir, input logic busy,
                      input logic [5:0] ectrl, input state_e est);
    @(negedge clk);
    id_valid_i = iv; rs1_addr_i = r1; rs1_used_i = u1; rs2_addr_i = r2; rs2_used_i = u2;
    rd_addr_i = rd; rd_we_i = we; wb_valid_i = wv; wb_rd_addr_i = wrd; wb_rd_we_i = wv;
    exe_redirect_i = redir; mem_busy_i = busy;
    exp_ctrl_q.push_back(ectrl);
    exp_state_q.push_back(2'(est));
    #1;
    chk({tag, "/ctrl"}, 32'(ctrl), 32'(exp_ctrl_q.pop_front()));
    @(posedge clk);
    #1;
    chk({tag, "/state"}, 32'(state_o), 32'(exp_state_q.pop_front()));
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    #12;
    chk("rst/ctrl", 32'(ctrl), 32'(C_IDLE));
    chk("rst/state", 32'(state_o), 32'(ST_RUN));
    chk("rst/err", 32'(sb_err_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    //   tag            iv r1 u1 r2 u2 rd we wv wrd red busy ctrl    state
    step("issue_x5",    1, 0, 0, 0, 0, 5, 1, 0, 0,  0,  0,   C_ISS,  ST_RUN);
    chk("cnt5_a", 32'(dut.u_sb.cnt_q[5]), 32'd1);
    step("raw_x5",      1, 5, 1, 0, 0, 6, 1, 0, 0,  0,  0,   C_HAZ,  ST_HAZ);
    chk("cnt5_b", 32'(dut.u_sb.cnt_q[5]), 32'd1);
    chk("cnt6_b", 32'(dut.u_sb.cnt_q[6]), 32'd0);
    step("raw_x5_wt",   1, 5, 1, 0, 0, 5, 1, 1, 5,  0,  0,   C_ISS,  ST_RUN);
    chk("cnt5_c", 32'(dut.u_sb.cnt_q[5]), 32'd1);
    step("redir_haz",   1, 5, 1, 0, 0, 5, 1, 0, 0,  1,  0,   C_FL,   ST_FLUSH);
    chk("cnt5_d", 32'(dut.u_sb.cnt_q[5]), 32'd1);
    step("wb_x5",       0, 0, 0, 0, 0, 0, 0, 1, 5,  0,  0,   C_IDLE, ST_RUN);
    chk("cnt5_e", 32'(dut.u_sb.cnt_q[5]), 32'd0);

    step("issue_x7",    1, 0, 0, 0, 0, 7, 1, 0, 0,  0,  0,   C_ISS,  ST_RUN);
    step("raw_x7_exe",  1, 7, 0, 7, 1, 0, 0, 0, 0,  0,  0,   C_HAZ,  ST_HAZ);
    step("raw_x7_mem",  1, 7, 0, 7, 1, 0, 0, 0, 0,  0,  0,   C_HAZ,  ST_HAZ);
    step("raw_x7_wb",   1, 7, 0, 7, 1, 0, 0, 1, 7,  0,  0,   C_ISS,  ST_RUN);
    chk("cnt7_a", 32'(dut.u_sb.cnt_q[7]), 32'd0);

    step("issue_x7b",   1, 0, 0, 0, 0, 7, 1, 0, 0,  0,  0,   C_ISS,  ST_RUN);
    step("mem_1",       1, 7, 1, 0, 0, 0, 0, 1, 7,  0,  1,   C_MEM,  ST_MEM);
    step("mem_2_redir", 1, 7, 1, 0, 0, 0, 0, 1, 7,  1,  1,   C_MEM,  ST_MEM);
    step("mem_3",       1, 7, 1, 0, 0, 0, 0, 1, 7,  0,  1,   C_MEM,  ST_MEM);
    chk("cnt7_frozen", 32'(dut.u_sb.cnt_q[7]), 32'd1);
    step("mem_release", 0, 0, 0, 0, 0, 0, 0, 1, 7,  0,  0,   C_IDLE, ST_RUN);
    chk("cnt7_b", 32'(dut.u_sb.cnt_q[7]), 32'd0);

    step("x0_access",   1, 0, 1, 0, 1, 0, 1, 1, 0,  0,  0,   C_ISS,  ST_RUN);
    chk("cnt0", 32'(dut.u_sb.cnt_q[0]), 32'd0);
    chk("err_x0", 32'(sb_err_o), 32'd0);
    step("wb_x3_under", 0, 0, 0, 0, 0, 0, 0, 1, 3,  0,  0,   C_IDLE, ST_RUN);
    chk("err_under", 32'(sb_err_o), 32'd1);
    chk("cnt3", 32'(dut.u_sb.cnt_q[3]), 32'd0);

`ifdef HAZ_CTRL_PERF_EN
    chk("perf_hz", hz_stall_cnt_o, 32'd3);
    chk("perf_mem", mem_stall_cnt_o, 32'd3);
    chk("perf_flush", flush_cnt_o, 32'd1);
`endif

    for (int k = 0; k < 4; k++)
      step("inc_x9",    1, 0, 0, 0, 0, 9, 1, 0, 0,  0,  0,   C_ISS,  ST_RUN);
    chk("cnt9_sat", 32'(dut.u_sb.cnt_q[9]), 32'd3);
    chk("err_sticky", 32'(sb_err_o), 32'd1);
    step("raw_x9",      1, 9, 1, 0, 0, 0, 0, 0, 0,  0,  0,   C_HAZ,  ST_HAZ);

    // Asynchronous reset in the middle of a stall.
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("mid_rst/state", 32'(state_o), 32'(ST_RUN));
    chk("mid_rst/err", 32'(sb_err_o), 32'd0);
    chk("mid_rst/cnt9", 32'(dut.u_sb.cnt_q[9]), 32'd0);
    chk("mid_rst/ctrl", 32'(ctrl), 32'(C_IDLE));
`ifdef HAZ_CTRL_PERF_EN
    chk("mid_rst/perf_hz", hz_stall_cnt_o, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    step("post_rst_x9", 1, 9, 1, 0, 0, 0, 0, 0, 0,  0,  0,   C_ISS,  ST_RUN);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
